// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: hazard priority,
// post-reset hold, debug halt, data-memory watchdog and stall counter.
module pipeline_ctrl #(
    parameter int unsigned RESET_HOLD_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT       = 64,
    parameter int unsigned CNT_WIDTH         = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 imem_ready_i,
    input  logic                 dmem_req_i,
    input  logic                 dmem_ready_i,
    input  logic                 ex_busy_i,
    input  logic                 branch_taken_i,
    input  logic                 load_use_i,
    input  logic                 halt_req_i,
    output logic                 pc_en_o,
    output logic                 pc_redirect_o,
    output logic                 if_id_en_o,
    output logic                 id_ex_en_o,
    output logic                 ex_mem_en_o,
    output logic                 mem_wb_en_o,
    output logic                 if_id_flush_o,
    output logic                 id_ex_flush_o,
    output logic                 ex_mem_flush_o,
    output logic                 halted_o,
    output logic                 mem_timeout_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o
);

    localparam int unsigned HOLD_W = 4;
    localparam int unsigned TO_W   = 10;

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_HALT,
        S_ERROR
    } state_t;

    state_t               r_state;
    logic [HOLD_W-1:0]    r_hold_cnt;
    logic [TO_W-1:0]      r_to_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic                 w_mem_stall;

    assign w_mem_stall   = dmem_req_i & ~dmem_ready_i;
    assign halted_o      = (r_state == S_HALT);
    assign mem_timeout_o = (r_state == S_ERROR);
    assign stall_cnt_o   = r_stall_cnt;

    // Zero-latency hazard resolution in RUN; every other state freezes the pipe.
    always_comb begin
        pc_en_o        = 1'b0;
        pc_redirect_o  = 1'b0;
        if_id_en_o     = 1'b0;
        id_ex_en_o     = 1'b0;
        ex_mem_en_o    = 1'b0;
        mem_wb_en_o    = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        if (r_state == S_RUN) begin
            pc_en_o     = 1'b1;
            if_id_en_o  = 1'b1;
            id_ex_en_o  = 1'b1;
            ex_mem_en_o = 1'b1;
            mem_wb_en_o = 1'b1;
            if (w_mem_stall) begin
                pc_en_o     = 1'b0;
                if_id_en_o  = 1'b0;
                id_ex_en_o  = 1'b0;
                ex_mem_en_o = 1'b0;
                mem_wb_en_o = 1'b0;
            end else if (ex_busy_i) begin
                pc_en_o        = 1'b0;
                if_id_en_o     = 1'b0;
                id_ex_en_o     = 1'b0;
                ex_mem_flush_o = 1'b1;
            end else if (branch_taken_i) begin
                pc_redirect_o = 1'b1;
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end else if (load_use_i) begin
                pc_en_o       = 1'b0;
                if_id_en_o    = 1'b0;
                id_ex_flush_o = 1'b1;
            end else if (!imem_ready_i) begin
                pc_en_o       = 1'b0;
                if_id_flush_o = 1'b1;
            end
        end
    end

    // State, hold/watchdog counters and the saturating stall counter.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state     <= S_HOLD;
            r_hold_cnt  <= '0;
            r_to_cnt    <= '0;
            r_stall_cnt <= '0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    r_to_cnt <= '0;
                    if (r_hold_cnt == HOLD_W'(RESET_HOLD_CYCLES - 1)) begin
                        r_state    <= S_RUN;
                        r_hold_cnt <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    if (!pc_en_o && !(&r_stall_cnt)) begin
                        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
                    end
                    if (w_mem_stall) begin
                        if (r_to_cnt == TO_W'(MEM_TIMEOUT - 1)) begin
                            r_state <= S_ERROR;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_W'(1);
                        end
                    end else begin
                        r_to_cnt <= '0;
                        if (halt_req_i && !ex_busy_i) begin
                            r_state <= S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    r_to_cnt <= '0;
                    if (!halt_req_i) begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_ERROR;
                end
            endcase
        end
    end

endmodule
